// File: rtl/pixel_group_responder.sv
// pixel_group_responder
//   Lower-level pixel group answering a 2-level arbiter. Pixel event levels are
//   latched into a request matrix. The matrix is presented to the arbiter, and
//   each request is cleared when its one-hot grant comes back. A consumed grant
//   is decoded into a registered row/column address. grp_free_o pulses when the
//   last request of the current pass is granted.
//
// Ports
//   grp_release_clk  clock; all state updates on its rising edge
//   reset_i          asynchronous, active-high reset
//   enable_i         group selected by the upper level; low freezes a pass
//   event_i          [ROWS][COLS] pixel event levels, sampled each edge
//   gnt_i            [ROWS][COLS] grant from the arbiter (one-hot or zero)
//   req_o            [ROWS][COLS] registered active request set
//   grp_free_o       pulse: last active request of the pass was granted
//   ev_valid_o       pulse: a legal grant was consumed
//   ev_x_o / ev_y_o  row / column of the last consumed grant (held)
//   pend_cnt_o       popcount of req_o, registered alongside it
//   gnt_err_o        pulse: an illegal grant was ignored
//   overflow_o       sticky: an event was lost to an already-set shadow bit
module pixel_group_responder #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int ADD   = 2,
  parameter int CNT_W = $clog2(ROWS*COLS+1)
) (
  input  logic                       grp_release_clk,
  input  logic                       reset_i,
  input  logic                       enable_i,
  input  logic [ROWS-1:0][COLS-1:0]  event_i,
  input  logic [ROWS-1:0][COLS-1:0]  gnt_i,
  output logic [ROWS-1:0][COLS-1:0]  req_o,
  output logic                       grp_free_o,
  output logic                       ev_valid_o,
  output logic [ADD-1:0]             ev_x_o,
  output logic [ADD-1:0]             ev_y_o,
  output logic [CNT_W-1:0]           pend_cnt_o,
  output logic                       gnt_err_o,
  output logic                       overflow_o
);

  localparam int N = ROWS * COLS;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t           state_q, state_n;
  logic [N-1:0]     active_q, active_n;
  logic [N-1:0]     shadow_q, shadow_n;
  logic [N-1:0]     ev_flat, gnt_flat, gnt_cleared;
  logic             gnt_any, gnt_onehot, gnt_in_active, load;
  logic [ADD-1:0]   gnt_row, gnt_col;
  logic [ADD-1:0]   ev_x_n, ev_y_n;
  logic             free_n, valid_n, err_n, ovf_n;

  assign ev_flat  = event_i;
  assign gnt_flat = gnt_i;
  assign req_o    = active_q;

  assign gnt_any       = |gnt_flat;
  assign gnt_onehot    = gnt_any && ((gnt_flat & (gnt_flat - N'(1))) == '0);
  assign gnt_in_active = |(gnt_flat & active_q);
  assign gnt_cleared   = active_q & ~gnt_flat;

  // A pass starts only from IDLE with the group enabled and something pending.
  assign load = (state_q == IDLE) && enable_i && (|(shadow_q | ev_flat));

  function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  always_comb begin
    gnt_row = '0;
    gnt_col = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (gnt_i[r][c]) begin
          gnt_row = ADD'(r);
          gnt_col = ADD'(c);
        end
      end
    end
  end

  always_comb begin
    state_n  = state_q;
    active_n = active_q;
    shadow_n = shadow_q | ev_flat;
    ev_x_n   = ev_x_o;
    ev_y_n   = ev_y_o;
    free_n   = 1'b0;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    // Events that are moved into active on a load edge are not lost, even if
    // the same shadow bit was already set.
    ovf_n    = overflow_o | ((|(ev_flat & shadow_q)) && !load);

    unique case (state_q)
      IDLE: begin
        if (load) begin
          active_n = shadow_q | ev_flat;
          shadow_n = '0;
          state_n  = SERVE;
        end
        if (gnt_any) begin
          err_n = 1'b1;
        end
      end
      SERVE: begin
        if (enable_i && gnt_any) begin
          if (gnt_onehot && gnt_in_active) begin
            active_n = gnt_cleared;
            valid_n  = 1'b1;
            ev_x_n   = gnt_row;
            ev_y_n   = gnt_col;
            if (gnt_cleared == '0) begin
              free_n  = 1'b1;
              state_n = IDLE;
            end
          end else begin
            err_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge grp_release_clk or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      active_q   <= '0;
      shadow_q   <= '0;
      ev_x_o     <= '0;
      ev_y_o     <= '0;
      pend_cnt_o <= '0;
      grp_free_o <= 1'b0;
      ev_valid_o <= 1'b0;
      gnt_err_o  <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      state_q    <= state_n;
      active_q   <= active_n;
      shadow_q   <= shadow_n;
      ev_x_o     <= ev_x_n;
      ev_y_o     <= ev_y_n;
      pend_cnt_o <= popcount(active_n);
      grp_free_o <= free_n;
      ev_valid_o <= valid_n;
      gnt_err_o  <= err_n;
      overflow_o <= ovf_n;
    end
  end

endmodule

// File: doc/pixel_group_responder.md
# pixel_group_responder

Lower-level pixel group that answers a 2-level arbiter. Latches asynchronous pixel events into a request matrix, presents it to the arbiter, and clears each request as its one-hot grant returns. Decodes the grant into a registered row/column event address and pulses a group-free indication when the last pending request of the current pass is granted. Runs entirely on the arbiter's group release clock; one instance per group below the top-level arbiter.

## Interface
- ROWS, 4: pixel rows in the group
- COLS, 4: pixel columns in the group
- ADD, 2: address width; ADD ≥ clog2(max(ROWS,COLS))
- CNT_W, clog2(ROWS*COLS+1): pending-count width

- grp_release_clk  in  1  clock; all state updates on its rising edge
- reset_i  in  1  asynchronous, active-high reset
- enable_i  in  1  group selected by upper level; low freezes the serving pass
- event_i  in  [ROWS][COLS]  pixel event levels, sampled each edge
- gnt_i  in  [ROWS][COLS]  grant from arbiter; one-hot or zero
- req_o  out  [ROWS][COLS]  registered active request set
- grp_free_o  out  1  one-cycle pulse: last active request granted
- ev_valid_o  out  1  one-cycle pulse: a legal grant was consumed
- ev_x_o  out  ADD  row of consumed grant
- ev_y_o  out  ADD  column of consumed grant
- pend_cnt_o  out  CNT_W  popcount of req_o (registered)
- gnt_err_o  out  1  one-cycle pulse: illegal grant ignored
- overflow_o  out  1  sticky: event lost to an already-set shadow bit

## Operation
- Two registered matrices: active (drives req_o) and shadow (events arriving during a pass).
- FSM states IDLE, SERVE.
- IDLE, active = 0:
  - enable_i=1 and (shadow | event_i) ≠ 0 → active ← shadow | event_i, shadow ← 0, go SERVE.
  - Otherwise shadow ← shadow | event_i.
- SERVE:
  - New events always OR into shadow, never into active.
  - Legal grant: gnt_i exactly one-hot, that bit set in active, enable_i=1. Clear the bit and register ev_x_o/ev_y_o = (row, col). Pulse ev_valid_o.
  - If that bit was the only one set: pulse grp_free_o and go IDLE.
  - enable_i=0: active, state and address outputs hold; gnt_i ignored without error.
- Illegal grant (multi-hot; bit not in active; any nonzero gnt_i in IDLE): no state change, gnt_err_o pulses.
- Overflow: event_i bit set while the same shadow bit is already set and the event is not being moved into active that edge → overflow_o ← 1. Cleared only by reset.
- Same-edge grant and event on one pixel in SERVE: active bit clears, event goes to shadow.
- pend_cnt_o tracks popcount of the next active value, registered with req_o.

## Timing
- Reset values: state IDLE; active, shadow, req_o = 0; grp_free_o, ev_valid_o, gnt_err_o, overflow_o = 0; ev_x_o, ev_y_o, pend_cnt_o = 0.
- Reset mid-pass discards all pending and shadow requests.
- Event to req_o: 1 edge when IDLE and enabled; otherwise deferred to the first IDLE edge with enable_i=1.
- Grant to req_o bit clear, ev_valid_o and address: same edge (1-edge latency).
- grp_free_o is high for exactly the edge interval after the last grant; the next pass may load on the following edge.
- ev_x_o/ev_y_o hold their last value between grants.
- No combinational path from inputs to outputs.

## Test plan
- Reset then event_i bit(1,2) with enable_i=1 → req_o bit(1,2)=1, pend_cnt_o=1. Grant (1,2) → ev_valid_o=1, ev_x_o=1, ev_y_o=2, grp_free_o=1, req_o=0, state IDLE.
- Load (0,0),(3,3); inject event (2,1) during SERVE → pass serves only 2 grants, grp_free_o on the second. The next edge loads (2,1), pend_cnt_o=1.
- Grant 0x0003 (two-hot) or grant to unrequested (2,2) → gnt_err_o pulse; req_o and pend_cnt_o unchanged.
- In SERVE, event (1,1) on two edges without moving to active → overflow_o=1 and stays 1 until reset.
- enable_i=0 in SERVE with grant (0,0) → no clear, no ev_valid_o, no gnt_err_o. Re-enable and grant → cleared normally.
- Assert reset_i asynchronously with 3 pending → all outputs 0 immediately; after release, event (3,0) loads normally.
